fp32_addtree5to1_src_packer: RTL and testbench

Producer-side feeder for the 8-channel FP32 5-to-1 adder-tree instruction. It accepts a stream of FP32 words over a valid/ready interface and gathers them into a 32-word batch (8 channels × 4 new operands). It scatters each batch into the nibble-sliced 8×128-bit source-register layout and issues a one-cycle instruction-valid pulse once a scheduler grant is received. It sits between the vector-load/datapath stream and the adder-tree instruction port.

---
 rtl/fp32_addtree5to1_src_packer.sv | 150 +++++++++++++++
 tb/tb_fp32_addtree5to1_src_packer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_addtree5to1_src_packer.sv
// Gathers 32 FP32 words (8 channels x 4 operands) and scatters them nibble-sliced into the
// adder-tree source registers; define FP32_PACK_DOUBLE_BUF_EN for ping-pong staging banks.
module fp32_addtree5to1_src_packer #(
  parameter logic [31:0] PAD_WORD  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  input  logic                 tree_grant,
  output logic                 cru_fp32addtree5to1,
  output logic [127:0]         dvr_fp32addtree5to1_s0,
  output logic [127:0]         dvr_fp32addtree5to1_s1,
  output logic [127:0]         dvr_fp32addtree5to1_s2,
  output logic [127:0]         dvr_fp32addtree5to1_s3,
  output logic [127:0]         dvr_fp32addtree5to1_s4,
  output logic [127:0]         dvr_fp32addtree5to1_s5,
  output logic [127:0]         dvr_fp32addtree5to1_s6,
  output logic [127:0]         dvr_fp32addtree5to1_s7,
  output logic                 batch_pending,
  output logic [CNT_WIDTH-1:0] batch_cnt
);

`ifdef FP32_PACK_DOUBLE_BUF_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  typedef enum logic {FILL = 1'b0, PEND = 1'b1} bank_state_e;

  // Single-bank builds never toggle the bank pointers, so bank 1 stays idle at PAD_WORD.
  bank_state_e          bank_st_q [2];
  bank_state_e          bank_st_d [2];
  logic                 fill_bank_q, fill_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [4:0]           wr_idx_q, wr_idx_d;
  logic [31:0]          stage_q [2][32];
  logic [127:0]         dvr_q [8];
  logic [127:0]         dvr_d [8];
  logic                 cru_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 accept;
  logic                 complete;
  logic                 issue;

  assign in_ready      = (bank_st_q[fill_bank_q] == FILL);
  assign batch_pending = (bank_st_q[0] == PEND) || (bank_st_q[1] == PEND);
  assign accept        = in_valid && in_ready;
  assign complete      = accept && (in_last || (wr_idx_q == 5'd31));
  assign issue         = (bank_st_q[rd_bank_q] == PEND) && tree_grant;

  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    fill_bank_d  = fill_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_idx_d     = wr_idx_q;
    if (accept) begin
      wr_idx_d = complete ? 5'd0 : wr_idx_q + 5'd1;
    end
    // Completion and issue always target different banks, so both may happen in one cycle.
    if (complete) begin
      bank_st_d[fill_bank_q] = PEND;
      fill_bank_d            = fill_bank_q ^ DB;
    end
    if (issue) begin
      bank_st_d[rd_bank_q] = FILL;
      rd_bank_d            = rd_bank_q ^ DB;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st_q[0] <= FILL;
      bank_st_q[1] <= FILL;
      fill_bank_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= 5'd0;
      cru_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      fill_bank_q  <= fill_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      cru_q        <= issue;
      if (issue) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Word y, nibble n lands in source register n at nibble position y.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      dvr_d[n] = '0;
      for (int y = 0; y < 32; y++) begin
        dvr_d[n][4*y +: 4] = stage_q[rd_bank_q][y][4*n +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int y = 0; y < 32; y++) begin
          stage_q[b][y] <= PAD_WORD;
        end
      end
    end else begin
      if (accept) begin
        stage_q[fill_bank_q][wr_idx_q] <= in_data;
      end
      if (issue) begin
        for (int y = 0; y < 32; y++) begin
          stage_q[rd_bank_q][y] <= PAD_WORD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) begin
        dvr_q[n] <= '0;
      end
    end else if (issue) begin
      for (int n = 0; n < 8; n++) begin
        dvr_q[n] <= dvr_d[n];
      end
    end
  end

  assign cru_fp32addtree5to1    = cru_q;
  assign batch_cnt              = cnt_q;
  assign dvr_fp32addtree5to1_s0 = dvr_q[0];
  assign dvr_fp32addtree5to1_s1 = dvr_q[1];
  assign dvr_fp32addtree5to1_s2 = dvr_q[2];
  assign dvr_fp32addtree5to1_s3 = dvr_q[3];
  assign dvr_fp32addtree5to1_s4 = dvr_q[4];
  assign dvr_fp32addtree5to1_s5 = dvr_q[5];
  assign dvr_fp32addtree5to1_s6 = dvr_q[6];
  assign dvr_fp32addtree5to1_s7 = dvr_q[7];

endmodule

// File: tb/tb_fp32_addtree5to1_src_packer.sv
// Scoreboard bench for fp32_addtree5to1_src_packer: stimulus pushes expected issues,
// a negedge monitor pops and compares on every instruction-valid pulse.
module tb_fp32_addtree5to1_src_packer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = 32'h0;
  logic         in_last = 1'b0;
  logic         tree_grant = 1'b0;
  logic         cru;
  logic [127:0] s0, s1, s2, s3, s4, s5, s6, s7;
  logic         batch_pending;
  logic [1:0]   batch_cnt;
  logic [7:0][127:0] dvr;

  always #5 clk = ~clk;

  fp32_addtree5to1_src_packer #(
    .PAD_WORD  (32'h0000_0000),
    .CNT_WIDTH (2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_data                (in_data),
    .in_last                (in_last),
    .tree_grant             (tree_grant),
    .cru_fp32addtree5to1    (cru),
    .dvr_fp32addtree5to1_s0 (s0),
    .dvr_fp32addtree5to1_s1 (s1),
    .dvr_fp32addtree5to1_s2 (s2),
    .dvr_fp32addtree5to1_s3 (s3),
    .dvr_fp32addtree5to1_s4 (s4),
    .dvr_fp32addtree5to1_s5 (s5),
    .dvr_fp32addtree5to1_s6 (s6),
    .dvr_fp32addtree5to1_s7 (s7),
    .batch_pending          (batch_pending),
    .batch_cnt              (batch_cnt)
  );

  assign dvr = {s7, s6, s5, s4, s3, s2, s1, s0};

`ifdef FP32_PACK_DOUBLE_BUF_EN
  localparam logic RDY_WHILE_ONE_PEND = 1'b1;
`else
  localparam logic RDY_WHILE_ONE_PEND = 1'b0;
`endif

  typedef struct packed {
    logic [7:0][127:0] s;
    logic [1:0]        cnt;
  } exp_t;

  exp_t              q[$];
  int                vectors = 0;
  int                miscompares = 0;
  int                stalls = 0;
  logic [1:0]        exp_cnt = 2'd0;
  logic [31:0]       wbuf [32];
  logic [7:0][127:0] last_dvr = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  function automatic logic [127:0] mk(input logic [3:0] hi, input logic [3:0] mid, input logic [3:0] lo);
    return {hi, {30{mid}}, lo};
  endfunction

  // Reference scatter, written bit-by-bit from the slot mapping.
  function automatic logic [127:0] ref_slice(input int n);
    logic [127:0] r;
    for (int b = 0; b < 128; b++) begin
      r[b] = wbuf[b / 4][4*n + (b % 4)];
    end
    return r;
  endfunction

  task automatic push_exp(input logic [7:0][127:0] s);
    exp_t e;
    exp_cnt = exp_cnt + 2'd1;
    e.s     = s;
    e.cnt   = exp_cnt;
    q.push_back(e);
  endtask

  task automatic push_ref();
    logic [7:0][127:0] s;
    for (int n = 0; n < 8; n++) begin
      s[n] = ref_slice(n);
    end
    push_exp(s);
  endtask

  task automatic clear_wbuf();
    for (int y = 0; y < 32; y++) begin
      wbuf[y] = 32'h0;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    if (!in_ready) stalls++;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready got 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_timeout: got %0d issues outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    exp_cnt = 2'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("rst_cru", cru, 1'b0);
    chk_bit("rst_pending", batch_pending, 1'b0);
    chk_bit("rst_in_ready", in_ready, 1'b1);
    chk("rst_batch_cnt", {126'b0, batch_cnt}, 128'b0);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("rst_dvr_s%0d", n), dvr[n], 128'b0);
    end
  endtask

  // Monitor: pops one expectation per pulse; between pulses dvr must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_dvr = '0;
    end else if (cru) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got cru=1 with cnt %0d, required no pulse", batch_cnt);
      end else begin
        e = q.pop_front();
        for (int n = 0; n < 8; n++) begin
          chk($sformatf("dvr_s%0d", n), dvr[n], e.s[n]);
        end
        chk("batch_cnt", {126'b0, batch_cnt}, {126'b0, e.cnt});
      end
      last_dvr = dvr;
    end else begin
      chk_bit("dvr_hold", (dvr == last_dvr), 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][127:0] s;
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();

    // Full batch layout with grant held high; also checks minimum issue latency.
    tree_grant = 1'b1;
    s[0] = mk(4'h8, 4'h0, 4'h1);
    s[1] = mk(4'h9, 4'h0, 4'h2);
    s[2] = mk(4'hA, 4'h0, 4'h3);
    s[3] = mk(4'hB, 4'h0, 4'h4);
    s[4] = mk(4'hC, 4'h0, 4'h5);
    s[5] = mk(4'hD, 4'h8, 4'h6);
    s[6] = mk(4'hE, 4'hF, 4'h7);
    s[7] = mk(4'hF, 4'h3, 4'h8);
    push_exp(s);
    send(32'h8765_4321, 1'b0);
    for (int y = 1; y < 31; y++) send(32'h3F80_0000, 1'b0);
    send(32'hFEDC_BA98, 1'b0);
    @(negedge clk);
    chk_bit("lat_cru_e0", cru, 1'b0);
    chk_bit("lat_pending_e0", batch_pending, 1'b1);
    @(negedge clk);
    chk_bit("lat_cru_e1", cru, 1'b1);
    chk_bit("lat_in_ready_e1", in_ready, 1'b1);
    drain();

    // Short batch; an in_last with in_valid low must be ignored.
    for (int n = 0; n < 8; n++) s[n] = {108'h0, 20'hFFFFF};
    push_exp(s);
    for (int y = 0; y < 4; y++) send(32'hFFFF_FFFF, 1'b0);
    in_last = 1'b1;
    in_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_last = 1'b0;
    send(32'hFFFF_FFFF, 1'b1);
    drain();
    chk_bit("short_pending_after", batch_pending, 1'b0);

    // Grant stall for 10 cycles, then one pulse.
    tree_grant = 1'b0;
    for (int y = 0; y < 32; y++) wbuf[y] = 32'h1357_9BDF ^ (32'h0101_0101 * 32'(y));
    push_ref();
    for (int y = 0; y < 32; y++) send(wbuf[y], 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_bit("stall_cru", cru, 1'b0);
      chk_bit("stall_in_ready", in_ready, RDY_WHILE_ONE_PEND);
      chk_bit("stall_pending", batch_pending, 1'b1);
    end
    tree_grant = 1'b1;
    @(negedge clk);
    chk_bit("stall_release_cru", cru, 1'b1);
    chk_bit("stall_release_in_ready", in_ready, 1'b1);
    drain();

`ifdef FP32_PACK_DOUBLE_BUF_EN
    // Two banks fill back-to-back without a bubble, then issue in order.
    tree_grant = 1'b0;
    stalls = 0;
    for (int b = 0; b < 2; b++) begin
      for (int y = 0; y < 32; y++) wbuf[y] = 32'h0F1E_2D3C + 32'(b * 64 + y);
      push_ref();
      for (int y = 0; y < 32; y++) send(wbuf[y], 1'b0);
    end
    chk("db_stalls", 128'(stalls), 128'd0);
    @(negedge clk);
    chk_bit("db_full_in_ready", in_ready, 1'b0);
    chk_bit("db_full_pending", batch_pending, 1'b1);
    tree_grant = 1'b1;
    drain();
    chk_bit("db_after_in_ready", in_ready, 1'b1);
`endif

    // Reset mid-fill discards the partial batch.
    tree_grant = 1'b1;
    for (int y = 0; y < 10; y++) send(32'hAAAA_5555, 1'b0);
    pulse_reset();
    for (int n = 0; n < 8; n++) s[n] = 128'h0;
    s[7] = {32{4'h4}};
    push_exp(s);
    for (int y = 0; y < 32; y++) send(32'h4000_0000, 1'b0);
    drain();

    // Partial fill, reset, then one-word batches: staging must be back at PAD and cnt wraps.
    for (int y = 0; y < 3; y++) send(32'hFFFF_FFFF, 1'b0);
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      clear_wbuf();
      wbuf[0] = 32'h8765_4321 + 32'(i);
      push_ref();
      send(wbuf[0], 1'b1);
      drain();
    end
    chk_bit("end_pending", batch_pending, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
